// File: rtl/lsu_mem_port.sv
// Load/store unit with a handshaked, variable-latency memory port; one transaction in flight.
// Optional response watchdog is compiled in with `define LSU_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [2:0]        i_req_funct3,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic [1:0]        o_rsp_cause,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_mask,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rsp_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_d;
  logic            r_wen;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_trap;
  logic [1:0]      r_cause;

  logic             w_legal;
  logic             w_misal;
  logic             w_tmo;
  logic [OFF_W-1:0] w_off;
  logic [3:0]       w_size;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_ext;
  logic [NB-1:0]    w_mask;
  logic             w_sign;
  logic             w_fill;
  logic             w_issue;
  logic             w_resp;

  // Decode of the incoming request; only meaningful while idle.
  always_comb begin
    w_legal = 1'b0;
    if (i_req_wen) begin
      case (i_req_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (i_req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end
    w_misal = 1'b0;
    case (i_req_funct3[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = i_req_addr[0];
      2'b10:   w_misal = |i_req_addr[1:0];
      default: w_misal = |i_req_addr[2:0];
    endcase
  end

  assign w_off     = r_addr[OFF_W-1:0];
  assign w_size    = 4'd1 << r_funct3[1:0];
  assign w_shifted = i_mem_rsp_rdata >> {w_off, 3'b000};

  // Byte-lane mask and load extension, built lane by lane.
  always_comb begin
    w_sign = 1'b0;
    case (r_funct3[1:0])
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[XLEN-1];
    endcase
    w_fill = ~r_funct3[2] & w_sign;
    w_mask = '0;
    w_ext  = '0;
    for (int b = 0; b < NB; b++) begin
      w_mask[b] = (b >= int'(w_off)) && (b < int'(w_off) + int'(w_size));
      if (b < int'(w_size)) begin
        w_ext[8*b +: 8] = w_shifted[8*b +: 8];
      end else begin
        w_ext[8*b +: 8] = {8{w_fill}};
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_state_d = (!w_legal || w_misal) ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (i_mem_req_ready) begin
          w_state_d = StWait;
        end else if (w_tmo) begin
          w_state_d = StResp;
        end
      end
      StWait: begin
        if (i_mem_rsp_valid || w_tmo) begin
          w_state_d = StResp;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

  logic [CntW-1:0] r_tmo_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StIdle && w_state_d == StIssue) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == StIssue || r_state == StWait) && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // A response or acceptance in the expiry cycle still wins over the timeout.
  assign w_tmo = (r_tmo_cnt >= CntW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_wen    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_trap   <= 1'b0;
      r_cause  <= 2'd0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_wen    <= i_req_wen;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_rdata  <= '0;
            r_trap   <= !w_legal || w_misal;
            r_cause  <= w_legal ? 2'd0 : 2'd1;
          end
        end
        StIssue: begin
          if (!i_mem_req_ready && w_tmo) begin
            r_trap  <= 1'b1;
            r_cause <= 2'd2;
          end
        end
        StWait: begin
          if (i_mem_rsp_valid) begin
            r_rdata <= r_wen ? '0 : w_ext;
          end else if (w_tmo) begin
            r_trap  <= 1'b1;
            r_cause <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_issue = (r_state == StIssue);
  assign w_resp  = (r_state == StResp);

  assign o_req_ready     = (r_state == StIdle);
  assign o_rsp_valid     = w_resp;
  assign o_rsp_rdata     = w_resp ? r_rdata : '0;
  assign o_rsp_trap      = w_resp & r_trap;
  assign o_rsp_cause     = w_resp ? r_cause : 2'd0;
  assign o_mem_req_valid = w_issue;
  assign o_mem_addr      = w_issue ? {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_mem_wen       = w_issue & r_wen;
  assign o_mem_wdata     = w_issue ? (r_wdata << {w_off, 3'b000}) : '0;
  assign o_mem_mask      = w_issue ? w_mask : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised bench for lsu_mem_port: a 32-bit and a 64-bit instance checked against an
// arithmetic reference model of the load/store rules.
module tb_lsu_mem_port;

`ifdef LSU_TIMEOUT_EN
  localparam int MaxDly = 2;
`else
  localparam int MaxDly = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid     [2];
  logic        req_ready     [2];
  logic        req_wen       [2];
  logic [2:0]  req_f3        [2];
  logic [63:0] req_addr      [2];
  logic [63:0] req_wdata     [2];
  logic        rsp_valid     [2];
  logic [63:0] rsp_rdata     [2];
  logic        rsp_trap      [2];
  logic [1:0]  rsp_cause     [2];
  logic        mem_req_valid [2];
  logic        mem_req_ready [2];
  logic [63:0] mem_addr      [2];
  logic        mem_wen       [2];
  logic [63:0] mem_wdata     [2];
  logic [7:0]  mem_mask      [2];
  logic        mem_rsp_valid [2];
  logic [63:0] mem_rsp_rdata [2];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned XL = (g == 0) ? 32 : 64;
    logic [XL-1:0]   w_rdata;
    logic [XL-1:0]   w_maddr;
    logic [XL-1:0]   w_mwdata;
    logic [XL/8-1:0] w_mmask;

    lsu_mem_port #(.XLEN(XL), .TIMEOUT_CYCLES(4)) u_dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_req_valid     (req_valid[g]),
      .o_req_ready     (req_ready[g]),
      .i_req_wen       (req_wen[g]),
      .i_req_funct3    (req_f3[g]),
      .i_req_addr      (req_addr[g][XL-1:0]),
      .i_req_wdata     (req_wdata[g][XL-1:0]),
      .o_rsp_valid     (rsp_valid[g]),
      .o_rsp_rdata     (w_rdata),
      .o_rsp_trap      (rsp_trap[g]),
      .o_rsp_cause     (rsp_cause[g]),
      .o_mem_req_valid (mem_req_valid[g]),
      .i_mem_req_ready (mem_req_ready[g]),
      .o_mem_addr      (w_maddr),
      .o_mem_wen       (mem_wen[g]),
      .o_mem_wdata     (w_mwdata),
      .o_mem_mask      (w_mmask),
      .i_mem_rsp_valid (mem_rsp_valid[g]),
      .i_mem_rsp_rdata (mem_rsp_rdata[g][XL-1:0])
    );

    assign rsp_rdata[g] = 64'(w_rdata);
    assign mem_addr[g]  = 64'(w_maddr);
    assign mem_wdata[g] = 64'(w_mwdata);
    assign mem_mask[g]  = 8'(w_mmask);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the port should do, from the ISA rules.
  task automatic model(input int xl, input bit wen, input bit [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, output bit trap, output logic [1:0] cause,
                       output logic [63:0] e_addr, output logic [63:0] e_wdata,
                       output logic [63:0] e_rdata, output logic [7:0] e_mask);
    logic [63:0] xm;
    logic [63:0] a;
    logic [63:0] v;
    logic [63:0] lm;
    int nb;
    int sz;
    int off;
    bit legal;
    xm  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a   = addr & xm;
    nb  = xl / 8;
    sz  = 1 << f3[1:0];
    off = int'(a % 64'(nb));
    if (wen) legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (xl == 64 && f3 == 3'd3);
    else legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                 (xl == 64 && (f3 inside {3'd3, 3'd6}));
    trap    = !legal || (a % 64'(sz) != 0);
    cause   = legal ? 2'd0 : 2'd1;
    e_addr  = a - 64'(off);
    e_mask  = 8'(((1 << sz) - 1) << off);
    e_wdata = ((wdata & xm) << (8 * off)) & xm;
    v = (rdata & xm) >> (8 * off);
    if (sz < 8) begin
      lm = (64'd1 << (8 * sz)) - 64'd1;
      v  = v & lm;
      if (!f3[2] && v[8*sz-1]) v = v | ~lm;
    end
    e_rdata = wen ? 64'd0 : (v & xm);
  endtask

  task automatic check_idle(input int k);
    check_eq("idle.req_ready", 64'(req_ready[k]), 64'd1);
    check_eq("idle.rsp_valid", 64'(rsp_valid[k]), 64'd0);
    check_eq("idle.rsp_trap", 64'(rsp_trap[k]), 64'd0);
    check_eq("idle.rsp_cause", 64'(rsp_cause[k]), 64'd0);
    check_eq("idle.rsp_rdata", rsp_rdata[k], 64'd0);
    check_eq("idle.mem_req_valid", 64'(mem_req_valid[k]), 64'd0);
    check_eq("idle.mem_addr", mem_addr[k], 64'd0);
    check_eq("idle.mem_wen", 64'(mem_wen[k]), 64'd0);
    check_eq("idle.mem_wdata", mem_wdata[k], 64'd0);
    check_eq("idle.mem_mask", 64'(mem_mask[k]), 64'd0);
  endtask

  // Drives one request at a negedge and checks every cycle until completion.
  task automatic run_txn(input int k, input bit wen, input bit [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int rdy_dly, input int rsp_dly);
    bit trap;
    logic [1:0] cause;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [7:0] e_mask;
    model((k == 0) ? 32 : 64, wen, f3, addr, wdata, rdata, trap, cause, e_addr, e_wdata,
          e_rdata, e_mask);
    @(negedge clk);
    check_eq("req_ready", 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_f3[k]    = f3;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(negedge clk);
    // Later changes to the request must not disturb the captured one.
    req_valid[k] = 1'b0;
    req_wen[k]   = 1'($urandom);
    req_f3[k]    = 3'($urandom);
    req_addr[k]  = {$urandom, $urandom};
    req_wdata[k] = {$urandom, $urandom};
    if (trap) begin
      check_eq("trap.rsp_valid", 64'(rsp_valid[k]), 64'd1);
      check_eq("trap.rsp_trap", 64'(rsp_trap[k]), 64'd1);
      check_eq("trap.rsp_cause", 64'(rsp_cause[k]), 64'(cause));
      check_eq("trap.rsp_rdata", rsp_rdata[k], 64'd0);
      check_eq("trap.mem_req_valid", 64'(mem_req_valid[k]), 64'd0);
      @(negedge clk);
      check_eq("trap.rsp_pulse", 64'(rsp_valid[k]), 64'd0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      check_eq("issue.mem_req_valid", 64'(mem_req_valid[k]), 64'd1);
      check_eq("issue.mem_addr", mem_addr[k], e_addr);
      check_eq("issue.mem_mask", 64'(mem_mask[k]), 64'(e_mask));
      check_eq("issue.mem_wen", 64'(mem_wen[k]), 64'(wen));
      check_eq("issue.mem_wdata", mem_wdata[k], e_wdata);
      check_eq("issue.rsp_valid", 64'(rsp_valid[k]), 64'd0);
      mem_req_ready[k] = (i == rdy_dly);
      @(negedge clk);
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      check_eq("wait.mem_req_valid", 64'(mem_req_valid[k]), 64'd0);
      check_eq("wait.rsp_valid", 64'(rsp_valid[k]), 64'd0);
      mem_req_ready[k] = 1'($urandom);
      mem_rsp_valid[k] = (i == rsp_dly);
      mem_rsp_rdata[k] = (i == rsp_dly) ? rdata : {$urandom, $urandom};
      @(negedge clk);
    end
    mem_rsp_valid[k] = 1'b0;
    mem_req_ready[k] = 1'b0;
    check_eq("rsp.rsp_valid", 64'(rsp_valid[k]), 64'd1);
    check_eq("rsp.rsp_trap", 64'(rsp_trap[k]), 64'd0);
    check_eq("rsp.rsp_rdata", rsp_rdata[k], e_rdata);
    check_eq("rsp.req_ready", 64'(req_ready[k]), 64'd0);
    @(negedge clk);
    check_eq("rsp.pulse", 64'(rsp_valid[k]), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]     = 1'b0;
      req_wen[k]       = 1'b0;
      req_f3[k]        = 3'd0;
      req_addr[k]      = '0;
      req_wdata[k]     = '0;
      mem_req_ready[k] = 1'b0;
      mem_rsp_valid[k] = 1'b0;
      mem_rsp_rdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle(0);
    check_idle(1);
    rst_n = 1'b1;

    // Directed cases.
    run_txn(0, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80FF_FF00, 0, 2);
    run_txn(0, 1'b1, 3'b001, 64'h2002, 64'h0000_ABCD, 64'h0, MaxDly, 0);
    run_txn(0, 1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 0);
    run_txn(1, 1'b0, 3'b110, 64'h4004, 64'h0, 64'h9000_0001_1234_5678, 0, 0);
    run_txn(1, 1'b0, 3'b111, 64'h4004, 64'h0, 64'h9000_0001_1234_5678, 0, 0);
    run_txn(1, 1'b0, 3'b011, 64'h8, 64'h0, 64'hFEDC_BA98_7654_3210, 1, 1);
    run_txn(0, 1'b0, 3'b011, 64'h8, 64'h0, 64'h0, 0, 0);
    run_txn(1, 1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 0, 1);
    run_txn(0, 1'b1, 3'b011, 64'h10, 64'h0, 64'h0, 0, 0);

    // Reset while waiting for the response; a stale response afterwards is ignored.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_f3[0]    = 3'b010;
    req_addr[0]  = 64'h500;
    @(negedge clk);
    req_valid[0]     = 1'b0;
    mem_req_ready[0] = 1'b1;
    @(negedge clk);
    mem_req_ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.req_ready", 64'(req_ready[0]), 64'd1);
    check_eq("rst.mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid[0] = 1'b1;
    mem_rsp_rdata[0] = 64'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst.no_rsp", 64'(rsp_valid[0]), 64'd0);
      check_eq("rst.idle", 64'(req_ready[0]), 64'd1);
      @(negedge clk);
    end

`ifdef LSU_TIMEOUT_EN
    // Memory never accepts: trap with cause 2 four cycles after entering ISSUE.
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_f3[0]    = 3'b010;
    req_addr[0]  = 64'h100;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("tmo.mem_req_valid", 64'(mem_req_valid[0]), 64'd1);
      check_eq("tmo.rsp_valid", 64'(rsp_valid[0]), 64'd0);
      @(negedge clk);
    end
    check_eq("tmo.rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check_eq("tmo.rsp_trap", 64'(rsp_trap[0]), 64'd1);
    check_eq("tmo.rsp_cause", 64'(rsp_cause[0]), 64'd2);
    check_eq("tmo.mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    @(negedge clk);
    mem_rsp_valid[0] = 1'b1;
    mem_req_ready[0] = 1'b1;
    @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    mem_req_ready[0] = 1'b0;
    check_eq("tmo.late_rsp", 64'(rsp_valid[0]), 64'd0);
    check_eq("tmo.idle", 64'(req_ready[0]), 64'd1);
`endif

    // Random traffic on both widths.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 250; n++) begin
        bit          wen;
        bit [2:0]    f3;
        logic [63:0] addr;
        int          rd;
        int          rs;
        wen  = 1'($urandom);
        f3   = 3'($urandom);
        addr = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
        rd = $urandom_range(0, MaxDly);
`ifdef LSU_TIMEOUT_EN
        rs = $urandom_range(0, MaxDly - rd);
`else
        rs = $urandom_range(0, MaxDly);
`endif
        run_txn(k, wen, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, rd, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
